// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// fills the IF/ID register, with stall, redirect and halt handling.
module instruction_fetch #(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 16'd1,
    parameter logic [4:0]              HALT_OPCODE = 5'b11010,
    parameter logic [INSTR_WIDTH-1:0]  BUBBLE      = 9'h000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    rom_pc,
    input  logic [INSTR_WIDTH-1:0] rom_instr,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_valid,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    localparam int unsigned OPCODE_WIDTH = 5;
    localparam int unsigned COUNT_WIDTH  = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [OPCODE_WIDTH-1:0] opcode;

    assign opcode = rom_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= BUBBLE;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Priority: redirect, then stall, then per-state fetch behaviour
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = BUBBLE;
            state_d = RUN;
        end else if (!stall) begin
            case (state_q)
                HALTED: begin
                    valid_d = 1'b0;
                    instr_d = BUBBLE;
                end
                default: begin
                    instr_d = rom_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    if (count_q != {COUNT_WIDTH{1'b1}}) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    // The halt instruction itself issues; only the PC freezes
                    if (opcode == HALT_OPCODE) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign rom_pc      = pc_q;
    assign if_instr    = instr_q;
    assign if_pc       = ipc_q;
    assign if_valid    = valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = count_q;

endmodule
